snoop_rr_arbiter: RTL and testbench
===================================

# snoop_rr_arbiter

Round-robin distributor between the single packet snooper and N parallel BPF VMs. It replaces the fixed-priority snoop arbiter chain and sits between the snooper and the VMs' snooper ports inside the parallel packet filter top level. It grants one ready VM per packet, holds that grant from the first write through `snooper_done`, then advances the rotation pointer so that load spreads evenly across the VMs. Write, address, data and done are forwarded through one register stage.

## Interface
Parameters:
- `N`, 5, number of VMs (2..32)
- `ADDR_WIDTH`, 9, snooper write address width
- `DATA_WIDTH`, 64, snooper write data width

Ports:
- `axi_aclk` in 1: the only clock
- `resetn` in 1: synchronous, active-low reset
- `snooper_wr_addr` in ADDR_WIDTH: write address from the snooper
- `snooper_wr_data` in DATA_WIDTH: write data from the snooper
- `snooper_wr_en` in 1: write strobe from the snooper
- `snooper_done` in 1: end of packet, 1-cycle pulse
- `ready_for_snooper` out 1: a VM is granted and the snooper may start or continue a packet
- `vm_ready` in N: per-VM `ready_for_snooper`
- `vm_wr_addr` out ADDR_WIDTH: registered copy of the address, broadcast to all VMs
- `vm_wr_data` out DATA_WIDTH: registered copy of the data, broadcast to all VMs
- `vm_wr_en` out N: one-hot registered write strobe
- `vm_done` out N: one-hot registered done pulse
- `grant_idx` out $clog2(N): index of the current or last granted VM
- `pkt_count` out 32: packets delivered (statistics feature only)
- `drop_count` out 16: orphan writes and dones (statistics feature only)

## Operation
- State machine states: IDLE, ARMED, BUSY.
- IDLE: `rr_pick` searches `vm_ready` starting at `ptr` and wrapping modulo N. On a hit, `sel`/`grant_idx` latch the hit index and the state moves to ARMED on the next cycle. With no hit, the block stays in IDLE.
- ARMED:
  - If `snooper_wr_en` is high, forward the write and go to BUSY.
  - If `vm_ready[sel]` drops and no write has been seen, go back to IDLE with `ptr` unchanged.
- BUSY: forward every `snooper_wr_en`. `vm_ready` is ignored while BUSY.
- `snooper_done` in ARMED or BUSY:
  - forward it as `vm_done[sel]`;
  - set `ptr <= (sel==N-1) ? 0 : sel+1`;
  - go to IDLE.
- `snooper_done` arriving in ARMED with no writes gives a zero-length packet. It is still forwarded.
- `ready_for_snooper` = (state==ARMED || state==BUSY). It is combinational from the state register.
- `snooper_wr_en` and `snooper_done` high in the same cycle: the write and the done are forwarded in the same output cycle, and the state goes to IDLE.
- Orphan events: `snooper_wr_en` or `snooper_done` arriving in IDLE is not forwarded and is counted as a drop.
- Output stage:
  - `vm_wr_en[i]` <= `snooper_wr_en` && granted && sel==i.
  - `vm_done` is formed the same way.
  - `vm_wr_addr`/`vm_wr_data` load on every accepted write and hold otherwise.

## Timing
- Reset (`resetn`=0 at a clock edge) sets:
  - state IDLE, `ptr` 0, `sel`/`grant_idx` 0;
  - `ready_for_snooper` 0;
  - `vm_wr_en` 0, `vm_done` 0, `vm_wr_addr` 0, `vm_wr_data` 0;
  - both counters 0.
- Reset asserted mid-packet abandons the packet. No `vm_done` is issued. The VMs are reset by the same `resetn`.
- Grant latency: a VM becoming ready in IDLE → `ready_for_snooper` high 1 cycle later.
- Forwarding latency: exactly 1 cycle for write and done. Ordering is preserved.
- After `snooper_done`, `ready_for_snooper` is low for at least 1 cycle (the IDLE pick cycle).
- The pointer wraps from N-1 to 0.
- Throughput: one write per cycle. No backpressure is applied once the state is ARMED or BUSY.

## Configuration
- Macro `SNOOP_ARB_STATS_EN`.
- Defined:
  - `pkt_count` increments once per forwarded done and wraps at 2^32.
  - `drop_count` increments once per cycle in which an orphan write and/or done occurs, and saturates at 0xFFFF.
  - Both are cleared by reset.
- Undefined: both ports are tied to 0 and no counter logic is generated.

## Structure
- Package `snoop_arb_pkg`:
  - state enum `arb_state_t` (IDLE=0, ARMED=1, BUSY=2);
  - `PKT_CNT_W`=32 and `DROP_CNT_W`=16.
- Sub-module `rr_pick`:
  - combinational rotate-priority search;
  - inputs `req[N]` and `ptr`;
  - outputs `hit` and `idx`.
- The FSM, output register stage and counters live in the top module.

## Test plan
- Rotation: N=5, all `vm_ready`=1, send 7 one-write packets → `vm_wr_en` one-hot sequence 0,1,2,3,4,0,1; `grant_idx` matches each packet.
- Skip busy VM: `ptr`=2, `vm_ready`=5'b01011 → grant VM3; `vm_ready`=5'b00011 → grant wraps to VM0.
- Latency: write addr 0x1A5, data 0xDEADBEEF_00C0FFEE at cycle t → `vm_wr_en[sel]`=1 with the same addr/data at t+1; done at t+3 → `vm_done[sel]` at t+4 and `ready_for_snooper`=0 at t+4.
- Same-cycle last write and done → both outputs high in one cycle; the next grant goes to the following VM.
- Orphan events: `snooper_done` while `vm_ready`=0 → no `vm_done` asserted; with `SNOOP_ARB_STATS_EN`, `drop_count`=1 and `pkt_count` unchanged.
- Reset mid-packet in BUSY → next cycle: all outputs 0, state IDLE, `ptr` 0; the following packet goes to VM0.

Source files
------------

// File: rtl/snoop_arb_pkg.sv
// ---------------------------------------------------------------------------
// snoop_arb_pkg
// Shared types and constants for the round-robin snooper distributor.
//   arb_state_t : arbiter FSM encoding (IDLE / ARMED / BUSY)
//   PKT_CNT_W   : width of the delivered-packet statistics counter
//   DROP_CNT_W  : width of the orphan-event statistics counter
// ---------------------------------------------------------------------------
package snoop_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    localparam int unsigned PKT_CNT_W  = 32;
    localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/snoop_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority search: finds the first set bit of req,
// starting at position ptr and wrapping modulo N.
//   req : per-requester request vector
//   ptr : starting search position (0..N-1)
//   hit : at least one request is set
//   idx : index of the first set request at or after ptr (valid when hit)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int unsigned N  = 5,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          hit,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;
    logic [IW:0]    wrapped;

    // Rotate so that bit 0 of rot corresponds to requester ptr.
    assign req_dbl = {req, req};
    assign rot     = N'(req_dbl >> ptr);

    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!hit && rot[i]) begin
                hit = 1'b1;
                off = IW'(i);
            end
        end
    end

    // Undo the rotation: idx = (ptr + off) mod N.
    assign sum     = {1'b0, ptr} + {1'b0, off};
    assign wrapped = sum - N_W;
    assign idx     = (sum >= N_W) ? wrapped[IW-1:0] : sum[IW-1:0];

endmodule

// File: rtl/snoop_rr_arbiter.sv
// ---------------------------------------------------------------------------
// snoop_rr_arbiter
// Round-robin distributor between one packet snooper and N parallel VMs.
// One ready VM is granted per packet; the grant is held from the first write
// through snooper_done, after which the rotation pointer moves past it.
// Write, address, data and done are forwarded through one register stage.
//
// Ports:
//   axi_aclk, resetn        : clock, synchronous active-low reset
//   snooper_wr_addr/_data   : write address/data from the snooper
//   snooper_wr_en           : write strobe from the snooper
//   snooper_done            : end-of-packet pulse from the snooper
//   ready_for_snooper       : a VM is granted (state ARMED or BUSY)
//   vm_ready[N]             : per-VM ready_for_snooper
//   vm_wr_addr/_data        : registered address/data broadcast to all VMs
//   vm_wr_en[N], vm_done[N] : one-hot registered write strobe / done pulse
//   grant_idx               : index of the current or last granted VM
//   pkt_count, drop_count   : statistics (zero unless SNOOP_ARB_STATS_EN)
//
// Build option: define SNOOP_ARB_STATS_EN to generate the packet and
// orphan-event counters; otherwise both ports are tied to zero.
// ---------------------------------------------------------------------------
module snoop_rr_arbiter
    import snoop_arb_pkg::*;
#(
    parameter int unsigned N          = 5,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                    axi_aclk,
    input  logic                    resetn,
    input  logic [ADDR_WIDTH-1:0]   snooper_wr_addr,
    input  logic [DATA_WIDTH-1:0]   snooper_wr_data,
    input  logic                    snooper_wr_en,
    input  logic                    snooper_done,
    output logic                    ready_for_snooper,
    input  logic [N-1:0]            vm_ready,
    output logic [ADDR_WIDTH-1:0]   vm_wr_addr,
    output logic [DATA_WIDTH-1:0]   vm_wr_data,
    output logic [N-1:0]            vm_wr_en,
    output logic [N-1:0]            vm_done,
    output logic [$clog2(N)-1:0]    grant_idx,
    output logic [PKT_CNT_W-1:0]    pkt_count,
    output logic [DROP_CNT_W-1:0]   drop_count
);

    localparam int unsigned   IW    = $clog2(N);
    localparam logic [IW-1:0] LAST  = IW'(N-1);
    localparam logic [N-1:0]  ONE_N = N'(1);

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       sel_q, sel_d;
    logic [N-1:0]        vm_wr_en_q, vm_wr_en_d;
    logic [N-1:0]        vm_done_q, vm_done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic          pick_hit;
    logic [IW-1:0] pick_idx;
    logic          granted;
    logic          accept_wr;
    logic          accept_done;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req (vm_ready),
        .ptr (ptr_q),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    // State register and output register stage.
    always_ff @(posedge axi_aclk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            vm_wr_en_q <= '0;
            vm_done_q  <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            vm_wr_en_q <= vm_wr_en_d;
            vm_done_q  <= vm_done_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    sel_d   = pick_idx;
                    state_d = ARMED;
                end
            end
            ARMED, BUSY: begin
                // Done takes priority: a write in the same cycle is still
                // forwarded by the output stage, but the packet ends here.
                if (snooper_done) begin
                    ptr_d   = (sel_q == LAST) ? '0 : sel_q + IW'(1);
                    state_d = IDLE;
                end else if (snooper_wr_en) begin
                    state_d = BUSY;
                end else if (state_q == ARMED && !vm_ready[sel_q]) begin
                    // Granted VM withdrew before any write: re-pick, same ptr.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        granted     = (state_q == ARMED) || (state_q == BUSY);
        accept_wr   = snooper_wr_en && granted;
        accept_done = snooper_done && granted;
        vm_wr_en_d  = accept_wr   ? (ONE_N << sel_q) : '0;
        vm_done_d   = accept_done ? (ONE_N << sel_q) : '0;
        addr_d      = accept_wr ? snooper_wr_addr : addr_q;
        data_d      = accept_wr ? snooper_wr_data : data_q;
    end

    assign ready_for_snooper = granted;
    assign vm_wr_en          = vm_wr_en_q;
    assign vm_done           = vm_done_q;
    assign vm_wr_addr        = addr_q;
    assign vm_wr_data        = data_q;
    assign grant_idx         = sel_q;

`ifdef SNOOP_ARB_STATS_EN
    logic [PKT_CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  orphan;

    always_comb begin
        orphan     = !granted && (snooper_wr_en || snooper_done);
        pkt_cnt_d  = accept_done ? pkt_cnt_q + PKT_CNT_W'(1) : pkt_cnt_q;
        drop_cnt_d = (orphan && drop_cnt_q != '1) ? drop_cnt_q + DROP_CNT_W'(1)
                                                  : drop_cnt_q;
    end

    always_ff @(posedge axi_aclk) begin
        if (!resetn) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_count  = pkt_cnt_q;
    assign drop_count = drop_cnt_q;
`else
    assign pkt_count  = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_snoop_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_snoop_rr_arbiter
// Directed bench for snoop_rr_arbiter (N=5). A vector table covers rotation,
// skipping of non-ready VMs and grant withdrawal; hand-written sequences cover
// latency, same-cycle write+done, zero-length packets, orphans and reset.
// ---------------------------------------------------------------------------
module tb_snoop_rr_arbiter;

    localparam int N  = 5;
    localparam int AW = 9;
    localparam int DW = 64;
    localparam int IW = $clog2(N);

`ifdef SNOOP_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic [AW-1:0] snooper_wr_addr;
    logic [DW-1:0] snooper_wr_data;
    logic          snooper_wr_en;
    logic          snooper_done;
    logic          ready_for_snooper;
    logic [N-1:0]  vm_ready;
    logic [AW-1:0] vm_wr_addr;
    logic [DW-1:0] vm_wr_data;
    logic [N-1:0]  vm_wr_en;
    logic [N-1:0]  vm_done;
    logic [IW-1:0] grant_idx;
    logic [31:0]   pkt_count;
    logic [15:0]   drop_count;

    always #5 clk = ~clk;

    snoop_rr_arbiter #(
        .N          (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .axi_aclk          (clk),
        .resetn            (resetn),
        .snooper_wr_addr   (snooper_wr_addr),
        .snooper_wr_data   (snooper_wr_data),
        .snooper_wr_en     (snooper_wr_en),
        .snooper_done      (snooper_done),
        .ready_for_snooper (ready_for_snooper),
        .vm_ready          (vm_ready),
        .vm_wr_addr        (vm_wr_addr),
        .vm_wr_data        (vm_wr_data),
        .vm_wr_en          (vm_wr_en),
        .vm_done           (vm_done),
        .grant_idx         (grant_idx),
        .pkt_count         (pkt_count),
        .drop_count        (drop_count)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]  rdy;
        logic          wr;
        logic          done;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          e_ready;
        logic [N-1:0]  e_wr;
        logic [N-1:0]  e_done;
        logic [IW-1:0] e_grant;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t          vecs[$];
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic e_ready, input logic [N-1:0] e_wr,
                             input logic [N-1:0] e_done, input logic [IW-1:0] e_grant,
                             input logic [AW-1:0] e_addr, input logic [DW-1:0] e_data);
        chk({name, ".ready"}, 64'(ready_for_snooper), 64'(e_ready));
        chk({name, ".wr_en"}, 64'(vm_wr_en), 64'(e_wr));
        chk({name, ".done"},  64'(vm_done), 64'(e_done));
        chk({name, ".grant"}, 64'(grant_idx), 64'(e_grant));
        chk({name, ".addr"},  64'(vm_wr_addr), 64'(e_addr));
        chk({name, ".data"},  vm_wr_data, e_data);
    endtask

    task automatic check_cnt(input string name, input int e_pkt, input int e_drop);
        chk({name, ".pkt_count"},  64'(pkt_count),  STATS ? 64'(e_pkt)  : 64'd0);
        chk({name, ".drop_count"}, 64'(drop_count), STATS ? 64'(e_drop) : 64'd0);
    endtask

    task automatic drive(input logic [N-1:0] rdy, input logic wr, input logic done,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        vm_ready        = rdy;
        snooper_wr_en   = wr;
        snooper_done    = done;
        snooper_wr_addr = addr;
        snooper_wr_data = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Append one vector; expected addr/data follow the last vector whose
    // expected write strobe is non-zero.
    task automatic add(input logic [N-1:0] rdy, input logic wr, input logic done,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic e_ready, input logic [N-1:0] e_wr,
                       input logic [N-1:0] e_done, input int e_grant);
        vec_t v;
        if (e_wr != '0) begin
            last_addr = addr;
            last_data = data;
        end
        v.rdy = rdy; v.wr = wr; v.done = done; v.addr = addr; v.data = data;
        v.e_ready = e_ready; v.e_wr = e_wr; v.e_done = e_done;
        v.e_grant = IW'(e_grant); v.e_addr = last_addr; v.e_data = last_data;
        vecs.push_back(v);
    endtask

    // Pick cycle, one write, then done.
    task automatic add_pkt(input int p, input logic [N-1:0] rdy, input int k);
        logic [N-1:0] oh;
        oh = N'(1) << p;
        add(rdy, 1'b0, 1'b0, '0, '0, 1'b1, '0, '0, p);
        add(rdy, 1'b1, 1'b0, AW'(9'h100 + k), {32'hA5A5_0000 + 32'(k), 32'(k * 3 + 1)},
            1'b1, oh, '0, p);
        add(rdy, 1'b0, 1'b1, '0, '0, 1'b0, '0, oh, p);
    endtask

    initial begin
        int rot_exp[7];
        rot_exp = '{0, 1, 2, 3, 4, 0, 1};

        // Vector table
        for (int k = 0; k < 7; k++) add_pkt(rot_exp[k], 5'b11111, k);
        add_pkt(3, 5'b01011, 7);   // ptr=2, VM2 not ready -> VM3
        add_pkt(0, 5'b00011, 8);   // ptr=4, VM4 not ready -> wraps to VM0
        // ptr=1: grant VM1, it withdraws before writing, re-grant VM1
        add(5'b00010, 1'b0, 1'b0, '0, '0, 1'b1, '0, '0, 1);
        add(5'b00000, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1);
        add(5'b11111, 1'b0, 1'b0, '0, '0, 1'b1, '0, '0, 1);
        add(5'b11111, 1'b1, 1'b0, 9'h0AA, 64'h0000_00AA_0000_00AA, 1'b1, 5'b00010, '0, 1);
        add(5'b11111, 1'b0, 1'b1, '0, '0, 1'b0, '0, 5'b00010, 1);

        // Reset
        resetn = 1'b0;
        drive('0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        check_all("reset", 1'b0, '0, '0, '0, '0, '0);
        check_cnt("reset", 0, 0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].rdy, vecs[i].wr, vecs[i].done, vecs[i].addr, vecs[i].data);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_wr, vecs[i].e_done,
                      vecs[i].e_grant, vecs[i].e_addr, vecs[i].e_data);
        end
        check_cnt("table", 10, 0);

        // Latency: ptr=2
        drive(5'b11111, 1'b0, 1'b0, '0, '0);
        tick();
        check_all("lat.pick", 1'b1, '0, '0, 2, 9'h0AA, 64'h0000_00AA_0000_00AA);
        drive(5'b11111, 1'b1, 1'b0, 9'h1A5, 64'hDEADBEEF_00C0FFEE);
        tick();
        check_all("lat.t1", 1'b1, 5'b00100, '0, 2, 9'h1A5, 64'hDEADBEEF_00C0FFEE);
        drive(5'b11111, 1'b0, 1'b0, 9'h0F0, 64'h1);
        tick();
        check_all("lat.t2", 1'b1, '0, '0, 2, 9'h1A5, 64'hDEADBEEF_00C0FFEE);
        tick();
        check_all("lat.t3", 1'b1, '0, '0, 2, 9'h1A5, 64'hDEADBEEF_00C0FFEE);
        drive(5'b11111, 1'b0, 1'b1, '0, '0);
        tick();
        check_all("lat.t4", 1'b0, '0, 5'b00100, 2, 9'h1A5, 64'hDEADBEEF_00C0FFEE);

        // Same-cycle last write and done: ptr=3
        drive(5'b11111, 1'b0, 1'b0, '0, '0);
        tick();
        check_all("same.pick", 1'b1, '0, '0, 3, 9'h1A5, 64'hDEADBEEF_00C0FFEE);
        drive(5'b11111, 1'b1, 1'b0, 9'h033, 64'h33);
        tick();
        check_all("same.wr", 1'b1, 5'b01000, '0, 3, 9'h033, 64'h33);
        drive(5'b11111, 1'b1, 1'b1, 9'h034, 64'h34);
        tick();
        check_all("same.wrdone", 1'b0, 5'b01000, 5'b01000, 3, 9'h034, 64'h34);
        drive(5'b11111, 1'b0, 1'b0, '0, '0);
        tick();
        check_all("same.next", 1'b1, '0, '0, 4, 9'h034, 64'h34);

        // Zero-length packet on VM4, pointer wraps to 0
        drive(5'b11111, 1'b0, 1'b1, '0, '0);
        tick();
        check_all("zlen.done", 1'b0, '0, 5'b10000, 4, 9'h034, 64'h34);
        check_cnt("zlen", 13, 0);

        // Orphan events with no VM ready
        drive(5'b00000, 1'b0, 1'b1, '0, '0);
        tick();
        check_all("orph.done", 1'b0, '0, '0, 4, 9'h034, 64'h34);
        check_cnt("orph.done", 13, 1);
        drive(5'b00000, 1'b1, 1'b1, 9'h1FF, 64'hFFFF);
        tick();
        check_all("orph.wrdone", 1'b0, '0, '0, 4, 9'h034, 64'h34);
        check_cnt("orph.wrdone", 13, 2);
        drive(5'b00000, 1'b0, 1'b0, '0, '0);
        tick();
        check_cnt("orph.quiet", 13, 2);

        // Reset mid-packet: packet on VM0, then VM1 in BUSY when reset hits
        drive(5'b11111, 1'b0, 1'b0, '0, '0);
        tick();
        check_all("rst.pick0", 1'b1, '0, '0, 0, 9'h034, 64'h34);
        drive(5'b11111, 1'b1, 1'b0, 9'h055, 64'h55);
        tick();
        drive(5'b11111, 1'b0, 1'b1, '0, '0);
        tick();
        check_all("rst.done0", 1'b0, '0, 5'b00001, 0, 9'h055, 64'h55);
        drive(5'b11111, 1'b0, 1'b0, '0, '0);
        tick();
        check_all("rst.pick1", 1'b1, '0, '0, 1, 9'h055, 64'h55);
        drive(5'b11111, 1'b1, 1'b0, 9'h066, 64'h66);
        tick();
        check_all("rst.busy", 1'b1, 5'b00010, '0, 1, 9'h066, 64'h66);
        resetn = 1'b0;
        drive(5'b11111, 1'b1, 1'b1, 9'h077, 64'h77);
        tick();
        check_all("rst.asserted", 1'b0, '0, '0, 0, '0, '0);
        check_cnt("rst.asserted", 0, 0);
        resetn = 1'b1;
        drive(5'b11111, 1'b0, 1'b0, '0, '0);
        tick();
        check_all("rst.repick", 1'b1, '0, '0, 0, '0, '0);
        drive(5'b11111, 1'b1, 1'b0, 9'h088, 64'h88);
        tick();
        check_all("rst.wr", 1'b1, 5'b00001, '0, 0, 9'h088, 64'h88);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
